// File: rtl/car_l2_pkg.sv
// Shared constants and Gray-code helpers for the L2 clock-domain-crossing ports.
package car_l2_pkg;

  localparam int unsigned DefLogDepth   = 3;
  localparam int unsigned DefSyncStages = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/l2_async_src_port_if.sv
// Bundle of the source-port handshakes and the async FIFO slot/pointer signals.
// master drives the port inputs (local client + far-side peer); slave is the port itself.
interface l2_async_src_port_if
  import car_l2_pkg::*;
#(
  parameter int unsigned LogDepth = DefLogDepth,
  parameter int unsigned ReqWidth = 64,
  parameter int unsigned RspWidth = 64
) (
  input logic clk
);

  logic [ReqWidth-1:0]              req_data;
  logic                             req_valid;
  logic                             req_ready;
  logic [(2**LogDepth)*ReqWidth-1:0] async_req_data;
  logic [LogDepth:0]                async_req_wptr;
  logic [LogDepth:0]                async_req_rptr;
  logic [(2**LogDepth)*RspWidth-1:0] async_rsp_data;
  logic [LogDepth:0]                async_rsp_wptr;
  logic [LogDepth:0]                async_rsp_rptr;
  logic [RspWidth-1:0]              rsp_data;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic                             err;

  modport master (
    input  clk, req_ready, async_req_data, async_req_wptr, async_rsp_rptr,
           rsp_data, rsp_valid, err,
    output req_data, req_valid, async_req_rptr, async_rsp_data, async_rsp_wptr, rsp_ready
  );

  modport slave (
    input  clk, req_data, req_valid, async_req_rptr, async_rsp_data, async_rsp_wptr, rsp_ready,
    output req_ready, async_req_data, async_req_wptr, async_rsp_rptr, rsp_data, rsp_valid, err
  );

endinterface

// File: rtl/l2_cdc_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer; latency Stages cycles, no backpressure.
module l2_cdc_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[Stages-1];

endmodule

// File: rtl/l2_async_src_port.sv
// Source half of a request/response async FIFO pair; pointers update 1 cycle after handshake,
// req_ready drops only on full and rsp_valid only on empty. Checker gated by CAR_L2_CDC_PROTO_CHK_EN.
module l2_async_src_port
  import car_l2_pkg::*;
#(
  parameter int unsigned LogDepth   = DefLogDepth,
  parameter int unsigned ReqWidth   = 64,
  parameter int unsigned RspWidth   = 64,
  parameter int unsigned SyncStages = DefSyncStages
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [ReqWidth-1:0]               req_data_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  output logic [(2**LogDepth)*ReqWidth-1:0] async_req_data_o,
  output logic [LogDepth:0]                 async_req_wptr_o,
  input  logic [LogDepth:0]                 async_req_rptr_i,
  input  logic [(2**LogDepth)*RspWidth-1:0] async_rsp_data_i,
  input  logic [LogDepth:0]                 async_rsp_wptr_i,
  output logic [LogDepth:0]                 async_rsp_rptr_o,
  output logic [RspWidth-1:0]               rsp_data_o,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic                              err_o
);

  localparam int unsigned PtrW  = LogDepth + 1;
  localparam int unsigned Depth = 2 ** LogDepth;
  // Full when the Gray pointers differ in exactly their two MSBs.
  localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (LogDepth - 1);

  logic [PtrW-1:0] wbin, wgray, wbin_nxt, rptr_sync;
  logic [PtrW-1:0] rbin, rgray, rbin_nxt, wptr_sync;
  logic [Depth-1:0][ReqWidth-1:0] req_slots;
  logic [Depth-1:0][RspWidth-1:0] rsp_slots;
  logic push, pop;

  l2_cdc_sync #(.Width(PtrW), .Stages(SyncStages)) u_rptr_sync (
    .clk(clk_i), .rst_n(rst_ni), .din(async_req_rptr_i), .dout(rptr_sync)
  );

  l2_cdc_sync #(.Width(PtrW), .Stages(SyncStages)) u_wptr_sync (
    .clk(clk_i), .rst_n(rst_ni), .din(async_rsp_wptr_i), .dout(wptr_sync)
  );

  assign req_ready_o      = (wgray ^ rptr_sync) != FullMask;
  assign push             = req_valid_i && req_ready_o;
  assign wbin_nxt         = wbin + PtrW'(1);
  assign async_req_data_o = req_slots;
  assign async_req_wptr_o = wgray;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wbin      <= '0;
      wgray     <= '0;
      req_slots <= '0;
    end else if (push) begin
      req_slots[wbin[LogDepth-1:0]] <= req_data_i;
      wbin                          <= wbin_nxt;
      wgray                         <= PtrW'(bin2gray(32'(wbin_nxt)));
    end
  end

  assign rsp_slots        = async_rsp_data_i;
  assign rsp_data_o       = rsp_slots[rbin[LogDepth-1:0]];
  assign rsp_valid_o      = rgray != wptr_sync;
  assign pop              = rsp_valid_o && rsp_ready_i;
  assign rbin_nxt         = rbin + PtrW'(1);
  assign async_rsp_rptr_o = rgray;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rbin  <= '0;
      rgray <= '0;
    end else if (pop) begin
      rbin  <= rbin_nxt;
      rgray <= PtrW'(bin2gray(32'(rbin_nxt)));
    end
  end

`ifdef CAR_L2_CDC_PROTO_CHK_EN
  // A stalled request must hold both valid and payload until accepted.
  logic                stall_q;
  logic [ReqWidth-1:0] data_q;
  logic                err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= req_valid_i && !req_ready_o;
      data_q  <= req_data_i;
      if (stall_q && (!req_valid_i || (req_data_i != data_q))) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l2_async_src_port.sv
// Bench for l2_async_src_port: directed scenarios plus a loopback peer with a scoreboard.
module tb_l2_async_src_port;
  import car_l2_pkg::*;

  localparam int unsigned LD = 3;
  localparam int unsigned RW = 64;
  localparam int unsigned SW = 64;
`ifdef CAR_L2_CDC_PROTO_CHK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [RW-1:0] req_q[$];
  logic [SW-1:0] rsp_q[$];

  always #5 clk = ~clk;

  l2_async_src_port_if #(.LogDepth(LD), .ReqWidth(RW), .RspWidth(SW)) bus (.clk(clk));

  l2_async_src_port #(.LogDepth(LD), .ReqWidth(RW), .RspWidth(SW), .SyncStages(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_data_i       (bus.req_data),
    .req_valid_i      (bus.req_valid),
    .req_ready_o      (bus.req_ready),
    .async_req_data_o (bus.async_req_data),
    .async_req_wptr_o (bus.async_req_wptr),
    .async_req_rptr_i (bus.async_req_rptr),
    .async_rsp_data_i (bus.async_rsp_data),
    .async_rsp_wptr_i (bus.async_rsp_wptr),
    .async_rsp_rptr_o (bus.async_rsp_rptr),
    .rsp_data_o       (bus.rsp_data),
    .rsp_valid_o      (bus.rsp_valid),
    .rsp_ready_i      (bus.rsp_ready),
    .err_o            (bus.err)
  );

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [RW-1:0] req_slot(input int idx);
    return bus.async_req_data[idx*RW +: RW];
  endfunction

  task automatic idle_inputs();
    bus.req_valid      = 1'b0;
    bus.req_data       = '0;
    bus.async_req_rptr = '0;
    bus.async_rsp_data = '0;
    bus.async_rsp_wptr = '0;
    bus.rsp_ready      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    n_tests++; if (bus.async_req_wptr !== 4'd0) begin n_fail++; $display("FAIL reset_wptr got %0d want 0", bus.async_req_wptr); end
    n_tests++; if (bus.async_rsp_rptr !== 4'd0) begin n_fail++; $display("FAIL reset_rptr got %0d want 0", bus.async_rsp_rptr); end
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", bus.err); end
    n_tests++; if (bus.async_req_data !== '0) begin n_fail++; $display("FAIL reset_slots got nonzero want 0"); end
    rst_n = 1'b1;
  endtask

  task automatic test_response();
    bus.async_rsp_data[0 +: SW] = 64'hA5;
    bus.async_rsp_wptr = 4'd1;
    rsp_q.push_back(64'hA5);
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_valid_early got %0b want 0", bus.rsp_valid); end
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_valid got %0b want 1", bus.rsp_valid); end
    if (rsp_q.size() > 0) begin
      logic [SW-1:0] exp;
      exp = rsp_q.pop_front();
      n_tests++; if (bus.rsp_data !== exp) begin n_fail++; $display("FAIL rsp_data got %h want %h", bus.rsp_data, exp); end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_tests++; if (bus.async_rsp_rptr !== 4'd1) begin n_fail++; $display("FAIL rsp_rptr_pop got %0d want 1", bus.async_rsp_rptr); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_valid_after_pop got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_fill();
    int unsigned wexp [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    req_q.delete();
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 64'h100 + 64'(i);
      req_q.push_back(bus.req_data);
      @(negedge clk);
      n_tests++; if (bus.async_req_wptr !== 4'(wexp[i])) begin n_fail++; $display("FAIL fill_wptr[%0d] got %0d want %0d", i, bus.async_req_wptr, wexp[i]); end
    end
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %0b want 0", bus.req_ready); end
    bus.req_data = 64'h1FF;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.async_req_wptr !== 4'd12) begin n_fail++; $display("FAIL fill_stall_wptr got %0d want 12", bus.async_req_wptr); end
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_stall_ready got %0b want 0", bus.req_ready); end
    for (int i = 0; i < 8; i++) begin
      logic [RW-1:0] exp;
      exp = req_q.pop_front();
      n_tests++; if (req_slot(i) !== exp) begin n_fail++; $display("FAIL fill_slot[%0d] got %h want %h", i, req_slot(i), exp); end
    end
  endtask

  task automatic test_drain_release();
    int accepted;
    logic hs;
    accepted = 0;
    bus.async_req_rptr = 4'd2;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_1cyc got %0b want 0", bus.req_ready); end
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_2cyc got %0b want 1", bus.req_ready); end
    for (int c = 0; c < 8; c++) begin
      hs = bus.req_valid && bus.req_ready;
      if (hs) begin
        req_q.push_back(bus.req_data);
        accepted++;
      end
      @(negedge clk);
      if (hs) bus.req_data = 64'h200 + 64'(accepted);
    end
    n_tests++; if (accepted != 3) begin n_fail++; $display("FAIL drain_accepted got %0d want 3", accepted); end
    n_tests++; if (bus.async_req_wptr !== 4'd14) begin n_fail++; $display("FAIL drain_wptr got %0d want 14", bus.async_req_wptr); end
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL drain_full_ready got %0b want 0", bus.req_ready); end
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL drain_err got %0b want 0", bus.err); end
    for (int i = 0; i < 3; i++) begin
      if (req_q.size() > 0) begin
        logic [RW-1:0] exp;
        exp = req_q.pop_front();
        n_tests++; if (req_slot(i) !== exp) begin n_fail++; $display("FAIL drain_slot[%0d] got %h want %h", i, req_slot(i), exp); end
      end
    end
  endtask

  task automatic test_protocol_err();
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL proto_err_before got %0b want 0", bus.err); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.err !== ExpErr) begin n_fail++; $display("FAIL proto_err got %0b want %0b", bus.err, ExpErr); end
    @(negedge clk);
    n_tests++; if (bus.err !== ExpErr) begin n_fail++; $display("FAIL proto_err_sticky got %0b want %0b", bus.err, ExpErr); end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 64'h300 + 64'(i);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n_tests++; if (bus.async_req_wptr !== 4'd7) begin n_fail++; $display("FAIL midrst_wptr_before got %0d want 7", bus.async_req_wptr); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.async_req_wptr !== 4'd0) begin n_fail++; $display("FAIL midrst_wptr got %0d want 0", bus.async_req_wptr); end
    n_tests++; if (bus.async_rsp_rptr !== 4'd0) begin n_fail++; $display("FAIL midrst_rptr got %0d want 0", bus.async_rsp_rptr); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %0b want 1", bus.req_ready); end
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %0b want 0", bus.err); end
    n_tests++; if (req_slot(0) !== '0) begin n_fail++; $display("FAIL midrst_slot0 got %h want 0", req_slot(0)); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] rsp_mem [8];
    logic [3:0] p_rbin, p_wbin, prev_w, prev_r;
    int sent, got;
    logic wrap_w, wrap_r;
    do_reset();
    req_q.delete();
    for (int k = 0; k < 8; k++) rsp_mem[k] = '0;
    p_rbin = '0; p_wbin = '0; prev_w = '0; prev_r = '0;
    sent = 0; got = 0; wrap_w = 1'b0; wrap_r = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 400 && got < 20; c++) begin
      @(negedge clk);
      if (prev_w == 4'd8 && bus.async_req_wptr == 4'd0) wrap_w = 1'b1;
      if (prev_r == 4'd8 && bus.async_rsp_rptr == 4'd0) wrap_r = 1'b1;
      prev_w = bus.async_req_wptr;
      prev_r = bus.async_rsp_rptr;
      // Far-side peer: move one request entry into the response FIFO per cycle.
      if (g2b(bus.async_req_wptr) != p_rbin && ((p_wbin - g2b(bus.async_rsp_rptr)) & 4'hF) < 4'd8) begin
        rsp_mem[p_wbin[2:0]] = req_slot(int'(p_rbin[2:0]));
        p_rbin = p_rbin + 4'd1;
        p_wbin = p_wbin + 4'd1;
        for (int k = 0; k < 8; k++) bus.async_rsp_data[k*SW +: SW] = rsp_mem[k];
        bus.async_req_rptr = b2g(p_rbin);
        bus.async_rsp_wptr = b2g(p_wbin);
      end
      bus.req_valid = (sent < 20);
      bus.req_data  = 64'(sent);
      #1;
      if (bus.req_valid && bus.req_ready) begin
        req_q.push_back(bus.req_data);
        sent++;
      end
      if (bus.rsp_valid) begin
        n_tests++;
        if (req_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected got %h want none", bus.rsp_data);
        end else begin
          logic [SW-1:0] exp;
          exp = req_q.pop_front();
          if (bus.rsp_data !== exp) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", got, bus.rsp_data, exp); end
        end
        got++;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    n_tests++; if (got != 20) begin n_fail++; $display("FAIL b2b_count got %0d want 20", got); end
    n_tests++; if (bus.async_req_wptr !== 4'd6) begin n_fail++; $display("FAIL b2b_wptr got %0d want 6", bus.async_req_wptr); end
    n_tests++; if (bus.async_rsp_rptr !== 4'd6) begin n_fail++; $display("FAIL b2b_rptr got %0d want 6", bus.async_rsp_rptr); end
    n_tests++; if (wrap_w !== 1'b1) begin n_fail++; $display("FAIL b2b_wptr_wrap got %0b want 1", wrap_w); end
    n_tests++; if (wrap_r !== 1'b1) begin n_fail++; $display("FAIL b2b_rptr_wrap got %0b want 1", wrap_r); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %0b want 0", bus.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_response();
    test_fill();
    test_drain_release();
    test_protocol_err();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/l2_async_src_port.md
L2_ASYNC_SRC_PORT -- requirements
Module: l2_async_src_port

Interface
REQ-001 SHALL have parameter LogDepth, default 3: log2 of slots per async FIFO.
REQ-002 SHALL have parameter ReqWidth, default 64: request payload bits.
REQ-003 SHALL have parameter RspWidth, default 64: response payload bits.
REQ-004 SHALL have parameter SyncStages, default 2: synchronizer flops per incoming pointer, minimum 2.
REQ-005 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock.
- rst_ni  in  1  synchronous, active-low reset.
- req_data_i  in  ReqWidth  request payload.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- async_req_data_o  out  (2**LogDepth)*ReqWidth  request slot storage.
- async_req_wptr_o  out  LogDepth+1  request write pointer, Gray code.
- async_req_rptr_i  in  LogDepth+1  request read pointer, Gray code, asynchronous.
- async_rsp_data_i  in  (2**LogDepth)*RspWidth  response slot storage.
- async_rsp_wptr_i  in  LogDepth+1  response write pointer, Gray code, asynchronous.
- async_rsp_rptr_o  out  LogDepth+1  response read pointer, Gray code.
- rsp_data_o  out  RspWidth  response payload.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- err_o  out  1  sticky protocol-error flag.

Function
REQ-006 SHALL store a request in slot wbin[LogDepth-1:0] on the clk_i edge where req_valid_i and req_ready_o are both 1, incrementing wbin in the same edge.
REQ-007 SHALL drive async_req_wptr_o from a register holding bin2gray(wbin), updated in the same edge as the slot write (1-cycle latency from handshake to pointer).
REQ-008 SHALL pass async_req_rptr_i through SyncStages flops before any use.
REQ-009 SHALL deassert req_ready_o only when full: wgray equals the synchronized rptr with its two MSBs inverted.
REQ-010 SHALL keep req_ready_o independent of req_valid_i.
REQ-011 SHALL pass async_rsp_wptr_i through SyncStages flops before any use.
REQ-012 SHALL assert rsp_valid_o when the registered rgray differs from the synchronized wptr (not empty).
REQ-013 SHALL drive rsp_data_o combinationally as the async_rsp_data_i slot indexed by rbin[LogDepth-1:0].
REQ-014 SHALL increment rbin on rsp_valid_o and rsp_ready_i, with async_rsp_rptr_o as bin2gray(rbin) registered.
REQ-015 SHALL wrap pointers modulo 2**(LogDepth+1) with no lost or duplicated entries.
REQ-016 SHALL leave slot storage unchanged when no handshake occurs.
REQ-017 SHALL treat a simultaneous push and full-release independently: ready is evaluated only on synchronized pointers.

Reset
REQ-018 SHALL, while rst_ni is 0 at a clk_i edge, clear wbin, rbin, all synchronizer flops, slot storage and err_o to 0.
REQ-019 SHALL hold outputs after reset at: req_ready_o=1, rsp_valid_o=0, both pointer outputs=0, err_o=0.
REQ-020 SHALL discard all in-flight entries on reset mid-operation; the peer side is reset in the same window.

Configuration
REQ-021 SHALL, with macro CAR_L2_CDC_PROTO_CHK_EN defined, set err_o sticky to 1 in the cycle after req_valid_i falls, or req_data_i changes, while req_valid_i=1 and req_ready_o=0.
REQ-022 SHALL, without CAR_L2_CDC_PROTO_CHK_EN, tie err_o to 0 and infer no checker logic.

Structure
REQ-023 SHALL place bin2gray/gray2bin functions and default LogDepth and SyncStages constants in car_l2_pkg.
REQ-024 SHALL implement synchronizers as one sub-module, l2_cdc_sync (parameters Width and Stages), instantiated twice.

Verification (LogDepth=3, SyncStages=2)
REQ-025 SHALL check reset: hold rst_ni=0 for 2 cycles -> all outputs 0 except req_ready_o=1.
REQ-026 SHALL check fill: 8 pushes with async_req_rptr_i=0 -> wptr sequence 1,3,2,6,7,5,4,12 (Gray); req_ready_o=0 after the 8th; a 9th request stalls.
REQ-027 SHALL check drain release: then set async_req_rptr_i=2 (binary 3) -> req_ready_o=1 two cycles later; exactly 3 pushes accepted; wptr=14.
REQ-028 SHALL check response: slot0=0xA5, async_rsp_wptr_i=1 -> rsp_valid_o=1 with data 0xA5 after 2 cycles; pop -> async_rsp_rptr_o=1 and rsp_valid_o=0.
REQ-029 SHALL check wrap: 20 back-to-back push/pop loopback transfers with data 0..19 -> received in order and pointers wrap 15->0.
REQ-030 SHALL check protocol: drop req_valid_i while full -> err_o=1 next cycle with the macro, 0 without; reset mid-fill with 5 entries -> pointers 0 next cycle.
